img_rsz_blk_sched: RTL and testbench
====================================

IMG_RSZ_BLK_SCHED -- requirements
Module: img_rsz_blk_sched

Interface
REQ-001 SHALL take parameter MAX_OUTSTD, default 2, meaning max blocks dispatched to the Compute Engine but not yet completed (range 1..15).
REQ-002 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port FrmStart  input  1  pulse that starts scheduling one resized frame.
REQ-005 SHALL have ports BlkDispX/BlkDispY  output  RSZ_IMG_WIDTH_IDX_W/RSZ_IMG_HEIGHT_IDX_W  coordinates of the block issued to the Compute Engine.
REQ-006 SHALL have ports BlkDispVld output 1 / BlkDispRdy input 1  valid/ready handshake for dispatch.
REQ-007 SHALL have ports BlkDoneX/BlkDoneY (IDX widths) input, BlkDoneVld input 1  Compute Engine completion report; always accepted.
REQ-008 SHALL have port BlkIsExec  output  [RSZ_IMG_WIDTH_SIZE-1:0] x RSZ_IMG_HEIGHT_SIZE  executed-block bitmap driving the forwarder.
REQ-009 SHALL have ports FlushBlkXMsk, FlushBlkYMsk (SIZE widths), FlushVld  input  flush request from the forwarder.
REQ-010 SHALL have ports Busy output 1 (not IDLE), FrmDone output 1 (one-cycle pulse), SchedErr output 1 (sticky error).

Function
REQ-011 SHALL implement FSM IDLE -> DISP -> DRAIN -> DONE -> IDLE.
REQ-012 IDLE: FrmStart=1 SHALL clear dispatch X/Y counters to 0 and enter DISP next cycle; FrmStart outside IDLE SHALL be ignored.
REQ-013 DISP: BlkDispVld SHALL be 1 iff outstanding count < MAX_OUTSTD; BlkDispX/Y SHALL equal the registered counters.
REQ-014 Dispatch handshake (Vld&Rdy) SHALL increment outstanding count and advance raster order: X++; at X=W-1 wrap X=0, Y++.
REQ-015 Handshake at (W-1,H-1) SHALL move to DRAIN; BlkDispVld SHALL be 0 outside DISP; Vld SHALL not drop without handshake except via Rst.
REQ-016 BlkDoneVld SHALL set BlkIsExec[BlkDoneY][BlkDoneX] and decrement outstanding count in the following cycle's state.
REQ-017 Same-cycle dispatch handshake and BlkDoneVld SHALL leave outstanding count unchanged.
REQ-018 FlushVld SHALL clear every bit [y][x] with FlushBlkYMsk[y]&FlushBlkXMsk[x]=1.
REQ-019 Same-cycle flush and done on the same bit: set SHALL win.
REQ-020 DRAIN SHALL go to DONE when outstanding count=0 and BlkIsExec all zero; DONE SHALL assert FrmDone for exactly one cycle then return to IDLE.
REQ-021 Outstanding count SHALL be clog2(MAX_OUTSTD+1) bits and never wrap; decrement at 0 SHALL hold 0.
REQ-022 Busy SHALL be 1 in DISP, DRAIN, DONE.

Reset
REQ-023 Rst SHALL force IDLE, counters 0, outstanding 0, BlkIsExec all 0, BlkDispVld 0, FrmDone 0, SchedErr 0, also when asserted mid-frame.

Configuration
REQ-024 With IMG_RSZ_SCHED_ERR_EN defined, SchedErr SHALL set (sticky until Rst) on BlkDoneVld with outstanding=0, or BlkDoneVld targeting an already-set bit not flushed in that cycle.
REQ-025 Without IMG_RSZ_SCHED_ERR_EN, SchedErr SHALL be tied 0 and no check logic synthesised; port list unchanged.

Structure
REQ-026 RSZ_IMG_WIDTH_SIZE, RSZ_IMG_HEIGHT_SIZE, IDX widths and the FSM state enum SHALL live in ImgRszPkg.
REQ-027 Bitmap set/clear SHALL be one sub-module img_rsz_blk_map (set port, 2D clear masks, bitmap out); FSM/counters stay in the top.

Verification (W=4, H=2, MAX_OUTSTD=2)
REQ-028 Rdy=1, no done -> dispatch (0,0),(1,0) then BlkDispVld=0, outstanding=2.
REQ-029 Full frame, done 2 cycles after each dispatch, forwarder flushes each bit -> 8 dispatches (3,0)->(0,1) wrap, FrmDone one pulse, Busy 0 after.
REQ-030 Done(2,1) and flush X=0100,Y=10 same cycle -> BlkIsExec[1][2]=1.
REQ-031 Rst in DRAIN with 3 bits set -> next cycle IDLE, bitmap 0, FrmStart restarts at (0,0).
REQ-032 ERR_EN defined: BlkDoneVld with outstanding=0 -> SchedErr=1 next cycle, held until Rst; undefined -> SchedErr stays 0.
REQ-033 FrmStart in DISP -> ignored, counters unchanged.

Source files
------------

// File: rtl/img_rsz_blk_sched_pkg.sv
// ============================================================================
// Module      : ImgRszPkg
// Description : Shared image geometry, index widths and scheduler state enum.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ImgRszPkg;

  localparam int RSZ_IMG_WIDTH_SIZE   = 4;
  localparam int RSZ_IMG_HEIGHT_SIZE  = 2;
  localparam int RSZ_IMG_WIDTH_IDX_W  = (RSZ_IMG_WIDTH_SIZE  > 1) ? $clog2(RSZ_IMG_WIDTH_SIZE)  : 1;
  localparam int RSZ_IMG_HEIGHT_IDX_W = (RSZ_IMG_HEIGHT_SIZE > 1) ? $clog2(RSZ_IMG_HEIGHT_SIZE) : 1;
  localparam int RSZ_IMG_BLK_NUM      = RSZ_IMG_WIDTH_SIZE * RSZ_IMG_HEIGHT_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DISP  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } schedState_t;

endpackage

`default_nettype wire

// File: rtl/img_rsz_blk_map.sv
// ============================================================================
// Module      : img_rsz_blk_map
// Description : Executed-block bitmap; bit [y*W+x]. Set wins over clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module img_rsz_blk_map
  import ImgRszPkg::*;
(
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            setVld,
  input  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  setX,
  input  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] setY,
  input  logic                            clrVld,
  input  logic [RSZ_IMG_WIDTH_SIZE-1:0]   clrXMsk,
  input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]  clrYMsk,
  output logic [RSZ_IMG_BLK_NUM-1:0]      blkMap
);

  for (genvar gy = 0; gy < RSZ_IMG_HEIGHT_SIZE; gy++) begin : g_row
    for (genvar gx = 0; gx < RSZ_IMG_WIDTH_SIZE; gx++) begin : g_col
      logic r_bit;
      logic w_set;
      logic w_clr;

      assign w_set = setVld && (setX == RSZ_IMG_WIDTH_IDX_W'(gx)) &&
                     (setY == RSZ_IMG_HEIGHT_IDX_W'(gy));
      assign w_clr = clrVld && clrXMsk[gx] && clrYMsk[gy];

      always_ff @(posedge Clk) begin
        if (Rst)        r_bit <= 1'b0;
        else if (w_set) r_bit <= 1'b1;
        else if (w_clr) r_bit <= 1'b0;
      end

      assign blkMap[gy*RSZ_IMG_WIDTH_SIZE + gx] = r_bit;
    end
  end

endmodule

`default_nettype wire

// File: rtl/img_rsz_blk_sched.sv
// ============================================================================
// Module      : img_rsz_blk_sched
// Description : Raster-order block dispatcher with outstanding-count limit and
//               executed-block tracking. Optional: IMG_RSZ_SCHED_ERR_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module img_rsz_blk_sched
  import ImgRszPkg::*;
#(
  parameter int MAX_OUTSTD = 2
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            FrmStart,
  output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  BlkDispX,
  output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] BlkDispY,
  output logic                            BlkDispVld,
  input  logic                            BlkDispRdy,
  input  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  BlkDoneX,
  input  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] BlkDoneY,
  input  logic                            BlkDoneVld,
  output logic [RSZ_IMG_BLK_NUM-1:0]      BlkIsExec,
  input  logic [RSZ_IMG_WIDTH_SIZE-1:0]   FlushBlkXMsk,
  input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]  FlushBlkYMsk,
  input  logic                            FlushVld,
  output logic                            Busy,
  output logic                            FrmDone,
  output logic                            SchedErr
);

  localparam int OUTSTD_W = $clog2(MAX_OUTSTD + 1);

  schedState_t                     r_state;
  schedState_t                     w_stateNxt;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  r_dispX;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] r_dispY;
  logic [OUTSTD_W-1:0]             r_outstd;
  logic                            w_dispHs;
  logic                            w_lastBlk;
  logic                            w_lastCol;

  assign BlkDispVld = (r_state == ST_DISP) && (r_outstd < OUTSTD_W'(MAX_OUTSTD));
  assign BlkDispX   = r_dispX;
  assign BlkDispY   = r_dispY;
  assign Busy       = (r_state != ST_IDLE);
  assign FrmDone    = (r_state == ST_DONE);
  assign w_dispHs   = BlkDispVld && BlkDispRdy;
  assign w_lastCol  = (r_dispX == RSZ_IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1));
  assign w_lastBlk  = w_lastCol && (r_dispY == RSZ_IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1));

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNxt;
  end

  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      ST_IDLE:  if (FrmStart) w_stateNxt = ST_DISP;
      ST_DISP:  if (w_dispHs && w_lastBlk) w_stateNxt = ST_DRAIN;
      ST_DRAIN: if ((r_outstd == '0) && (BlkIsExec == '0)) w_stateNxt = ST_DONE;
      ST_DONE:  w_stateNxt = ST_IDLE;
      default:  w_stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst || ((r_state == ST_IDLE) && FrmStart)) begin
      r_dispX <= '0;
      r_dispY <= '0;
    end else if (w_dispHs) begin
      if (w_lastCol) begin
        r_dispX <= '0;
        r_dispY <= r_dispY + RSZ_IMG_HEIGHT_IDX_W'(1);
      end else begin
        r_dispX <= r_dispX + RSZ_IMG_WIDTH_IDX_W'(1);
      end
    end
  end

  // Dispatch is gated by the limit, so increment never wraps; decrement saturates at 0.
  always_ff @(posedge Clk) begin
    if (Rst)                                          r_outstd <= '0;
    else if (w_dispHs && !BlkDoneVld)                 r_outstd <= r_outstd + OUTSTD_W'(1);
    else if (!w_dispHs && BlkDoneVld && (r_outstd != '0)) r_outstd <= r_outstd - OUTSTD_W'(1);
  end

  img_rsz_blk_map u_blkMap (
    .Clk     (Clk),
    .Rst     (Rst),
    .setVld  (BlkDoneVld),
    .setX    (BlkDoneX),
    .setY    (BlkDoneY),
    .clrVld  (FlushVld),
    .clrXMsk (FlushBlkXMsk),
    .clrYMsk (FlushBlkYMsk),
    .blkMap  (BlkIsExec)
  );

`ifdef IMG_RSZ_SCHED_ERR_EN
  logic r_schedErr;
  logic w_doneHit;

  assign w_doneHit = BlkIsExec[int'(BlkDoneY) * RSZ_IMG_WIDTH_SIZE + int'(BlkDoneX)] &&
                     !(FlushVld && FlushBlkXMsk[BlkDoneX] && FlushBlkYMsk[BlkDoneY]);

  always_ff @(posedge Clk) begin
    if (Rst)                                             r_schedErr <= 1'b0;
    else if (BlkDoneVld && ((r_outstd == '0) || w_doneHit)) r_schedErr <= 1'b1;
  end

  assign SchedErr = r_schedErr;
`else
  assign SchedErr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_img_rsz_blk_sched.sv
// ============================================================================
// Module      : tb_img_rsz_blk_sched
// Description : Directed plus randomized checks against a frame-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_img_rsz_blk_sched;
  import ImgRszPkg::*;

  localparam int W    = RSZ_IMG_WIDTH_SIZE;
  localparam int H    = RSZ_IMG_HEIGHT_SIZE;
  localparam int NB   = RSZ_IMG_BLK_NUM;
  localparam int MAXO = 2;
`ifdef IMG_RSZ_SCHED_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                            Clk = 1'b0;
  logic                            Rst, FrmStart, BlkDispRdy, BlkDoneVld, FlushVld;
  logic                            BlkDispVld, Busy, FrmDone, SchedErr;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  BlkDispX, BlkDoneX;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] BlkDispY, BlkDoneY;
  logic [NB-1:0]                   BlkIsExec;
  logic [W-1:0]                    FlushBlkXMsk;
  logic [H-1:0]                    FlushBlkYMsk;

  always #5 Clk = ~Clk;

  img_rsz_blk_sched #(.MAX_OUTSTD(MAXO)) dut (
    .Clk(Clk), .Rst(Rst), .FrmStart(FrmStart),
    .BlkDispX(BlkDispX), .BlkDispY(BlkDispY), .BlkDispVld(BlkDispVld), .BlkDispRdy(BlkDispRdy),
    .BlkDoneX(BlkDoneX), .BlkDoneY(BlkDoneY), .BlkDoneVld(BlkDoneVld),
    .BlkIsExec(BlkIsExec), .FlushBlkXMsk(FlushBlkXMsk), .FlushBlkYMsk(FlushBlkYMsk),
    .FlushVld(FlushVld), .Busy(Busy), .FrmDone(FrmDone), .SchedErr(SchedErr)
  );

  // Frame-level model: mode 0 idle, 1 dispatching, 2 draining, 3 done.
  typedef struct { int x; int y; int due; } ceJob_t;
  ceJob_t    ceQ[$];
  int        mMode, mPos, mOut, mHsCnt, mFrames;
  bit [NB-1:0] mMap;
  bit        mErr;
  int        nVec, nErr, cyc, dutDonePulses, ceFix;

  task automatic chk(input string tag, input int obs, input int exp);
    nVec++;
    if (obs != exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit expVld();
    return (mMode == 1) && (mOut < MAXO);
  endfunction

  task automatic checkOut();
    if (FrmDone) dutDonePulses++;
    chk("busy", int'(Busy), int'(mMode != 0));
    chk("frmdone", int'(FrmDone), int'(mMode == 3));
    chk("dispvld", int'(BlkDispVld), int'(expVld()));
    if (expVld()) begin
      chk("dispx", int'(BlkDispX), mPos % W);
      chk("dispy", int'(BlkDispY), mPos / W);
    end
    chk("bitmap", int'(BlkIsExec), int'(mMap));
    chk("schederr", int'(SchedErr), int'(mErr));
  endtask

  task automatic tick(input bit rst, input bit start, input bit rdy, input bit dv,
                      input int dx, input int dy, input bit fv, input int fxm, input int fym);
    bit hs, clr, hit;
    int nMode;
    bit [NB-1:0] nMap;
    Rst = rst; FrmStart = start; BlkDispRdy = rdy;
    BlkDoneVld = dv; BlkDoneX = dx[RSZ_IMG_WIDTH_IDX_W-1:0]; BlkDoneY = dy[RSZ_IMG_HEIGHT_IDX_W-1:0];
    FlushVld = fv; FlushBlkXMsk = fxm[W-1:0]; FlushBlkYMsk = fym[H-1:0];
    if (rst) begin
      mMode = 0; mPos = 0; mOut = 0; mMap = '0; mErr = 0;
      ceQ.delete();
    end else begin
      hs = expVld() && rdy;
      hit = dv && mMap[dy*W+dx] && !(fv && fym[dy] && fxm[dx]);
      if (ERR_EN && dv && (mOut == 0 || hit)) mErr = 1;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          clr = fv && fym[y] && fxm[x];
          if (dv && x == dx && y == dy) nMap[y*W+x] = 1'b1;
          else if (clr)                nMap[y*W+x] = 1'b0;
          else                         nMap[y*W+x] = mMap[y*W+x];
        end
      nMode = mMode;
      case (mMode)
        0: if (start) begin nMode = 1; mPos = 0; end
        1: if (hs) begin
             if (mPos == NB - 1) nMode = 2;
           end
        2: if (mOut == 0 && mMap == '0) nMode = 3;
        default: begin nMode = 0; mFrames++; end
      endcase
      if (hs) begin
        mHsCnt++;
        ceQ.push_back('{mPos % W, mPos / W,
                       cyc + 1 + ((ceFix >= 0) ? ceFix - 1 : int'($urandom_range(0, 3)))});
        if (mPos != NB - 1) mPos++;
      end
      mOut = mOut + (hs ? 1 : 0) - ((dv && (hs || mOut > 0)) ? 1 : 0);
      mMap = nMap;
      mMode = nMode;
    end
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    checkOut();
  endtask

  // Compute-engine and forwarder behaviour driven from the model's view.
  task automatic autoTick(input bit flushEn, input int rdyPct, input bit startEn);
    bit dv, fv;
    int dx, dy, fxm, fym, pick;
    dv = 0; dx = 0; dy = 0; fv = 0; fxm = 0; fym = 0;
    if (ceQ.size() > 0 && ceQ[0].due <= cyc) begin
      dv = 1; dx = ceQ[0].x; dy = ceQ[0].y;
      void'(ceQ.pop_front());
    end
    if (flushEn && mMap != '0 && $urandom_range(0, 2) == 0) begin
      fv = 1;
      if ($urandom_range(0, 3) == 0) begin
        fxm = int'($urandom_range(0, (1 << W) - 1));
        fym = int'($urandom_range(0, (1 << H) - 1));
      end else begin
        pick = int'($urandom_range(0, NB - 1));
        while (!mMap[pick]) pick = (pick + 1) % NB;
        fxm = 1 << (pick % W);
        fym = 1 << (pick / W);
      end
    end
    tick(0, startEn && ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < rdyPct),
         dv, dx, dy, fv, fxm, fym);
  endtask

  initial begin
    int f0, h0, budget;
    nVec = 0; nErr = 0; cyc = 0; dutDonePulses = 0; mFrames = 0; mHsCnt = 0; ceFix = -1;
    Rst = 1; FrmStart = 0; BlkDispRdy = 0; BlkDoneVld = 0; BlkDoneX = '0; BlkDoneY = '0;
    FlushVld = 0; FlushBlkXMsk = '0; FlushBlkYMsk = '0;
    @(negedge Clk);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0, 0, 0, 0);

    // Two dispatches then the outstanding limit holds Vld low.
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("outstd_cap_vld", int'(BlkDispVld), 0);

    // FrmStart while dispatching is ignored.
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("start_in_disp_x", int'(BlkDispX), 1);

    // Done and flush on the same bit: set wins; done with nothing outstanding.
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 2, 1, 1, 4'b0100, 2'b10);
    chk("set_wins_bit", int'(BlkIsExec[1*W+2]), 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", int'(SchedErr), int'(ERR_EN));
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while draining with bits still set.
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
    budget = 0;
    while (!(mMode == 2 && ceQ.size() == 0) && budget < 200) begin
      autoTick(0, 100, 0); budget++;
    end
    chk("drain_reach_timeout", int'(budget < 200), 1);
    tick(0, 0, 0, 0, 0, 0, 1, 4'b1111, 2'b01);
    tick(0, 0, 0, 0, 0, 0, 1, 4'b0001, 2'b10);
    chk("drain_three_bits", int'(BlkIsExec), int'(8'b1110_0000));
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Full frame, fixed completion latency, forwarder flushes.
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ceFix = 2; f0 = mFrames; h0 = mHsCnt; dutDonePulses = 0;
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
    budget = 0;
    while (mFrames == f0 && budget < 300) begin
      autoTick(1, 100, 0); budget++;
    end
    chk("frame_timeout", int'(budget < 300), 1);
    chk("frame_dispatches", mHsCnt - h0, NB);
    chk("frmdone_pulses", dutDonePulses, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized multi-frame run.
    ceFix = -1; f0 = mFrames; dutDonePulses = 0; budget = 0;
    while (mFrames - f0 < 6 && budget < 5000) begin
      autoTick(1, 60, 1); budget++;
    end
    chk("random_timeout", int'(budget < 5000), 1);
    chk("random_frmdone_pulses", dutDonePulses, mFrames - f0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

`default_nettype wire
